// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a 1-cycle-read-latency sync fifo into a valid/ready stream via a 2-entry buffer.
// f_rd->m_valid 2 cycles, 1 word/cycle sustained; m_ready low fills the buffer then stops reads. PKT_LAST_EN enables m_last.
module fifo_stream_out #(
  parameter int DBITS   = 3,
  parameter int PKT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_empty,
  output logic             f_rd,
  input  logic [DBITS-1:0] f_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DBITS-1:0] m_data,
  output logic             m_last,
  output logic [1:0]       occ
);

  if (PKT_LEN < 2 || PKT_LEN > 256) begin : g_bad_pkt_len
    $error("PKT_LEN must be in 2..256");
  end

  logic [DBITS-1:0] buf_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic             wr;
  logic             pop;
  logic [2:0]       level;

  assign wr  = inflight_q;
  assign pop = m_valid & m_ready;

  // The word already in flight is counted, so a read is only issued when a slot is guaranteed.
  assign level = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign f_rd  = ~rst & ~f_empty & (level < 3'd2);

  assign m_valid = ~rst & (occ_q != 2'd0);
  assign m_data  = rst ? '0 : buf_q[rd_ptr_q];
  assign occ     = rst ? 2'd0 : occ_q;

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (wr)  wr_ptr_d = ~wr_ptr_q;
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({wr, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= f_rd;
    end
  end

  // Data slots carry no reset; a read in flight at reset is dropped here.
  always_ff @(posedge clk) begin
    if (!rst && wr) buf_q[wr_ptr_q] <= f_dout;
  end

`ifdef PKT_LAST_EN
  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop) pkt_cnt_d = (pkt_cnt_q == CW'(PKT_LEN - 1)) ? '0 : pkt_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_d;
  end

  assign m_last = m_valid & (pkt_cnt_q == CW'(PKT_LEN - 1));
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural 1-cycle-latency source fifo.
module tb_fifo_stream_out;

`ifdef PKT_LAST_EN
  localparam bit LAST_ON = 1'b1;
`else
  localparam bit LAST_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f_empty;
  logic       f_rd;
  logic [2:0] f_dout = 3'd0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [2:0] m_data;
  logic       m_last;
  logic [1:0] occ;

  fifo_stream_out #(.DBITS(3), .PKT_LEN(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .f_empty (f_empty),
    .f_rd    (f_rd),
    .f_dout  (f_dout),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .occ     (occ)
  );

  always #5 clk = ~clk;

  // Source fifo model
  logic [2:0] mem [256];
  int wcnt = 0;
  int rcnt = 0;
  assign f_empty = (wcnt == rcnt);

  always @(posedge clk) begin
    if (f_rd) begin
      f_dout <= mem[rcnt];
      rcnt   <= rcnt + 1;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic push(input logic [2:0] v);
    mem[wcnt] = v;
    wcnt = wcnt + 1;
  endtask

  task automatic chk(input string name, input logic e_frd, input logic e_vld,
                     input logic [2:0] e_dat, input logic e_last, input logic [1:0] e_occ);
    logic bad;
    bad = (f_rd !== e_frd) || (m_valid !== e_vld) || (m_last !== e_last) || (occ !== e_occ);
    if ((e_vld || rst) && (m_data !== e_dat)) bad = 1'b1;
    vec_cnt++;
    if (bad) begin
      err_cnt++;
      $display("FAIL %s: got f_rd=%0b m_valid=%0b m_data=%0d m_last=%0b occ=%0d, want f_rd=%0b m_valid=%0b m_data=%0d m_last=%0b occ=%0d",
               name, f_rd, m_valid, m_data, m_last, occ, e_frd, e_vld, e_dat, e_last, e_occ);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    vec_cnt++;
    if (got != want) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic       push;
    logic [2:0] pval;
    logic       rdy;
    logic       e_frd;
    logic       e_vld;
    logic [2:0] e_dat;
    logic       e_last;
    logic [1:0] e_occ;
  } vec_t;

  vec_t tbl [26];

  initial begin
    //           name       rst push val rdy  frd vld dat last occ
    tbl[0]  = '{"rst0",     1, 1, 1, 0,  0, 0, 0, 0,       0};
    tbl[1]  = '{"rst1",     1, 1, 2, 0,  0, 0, 0, 0,       0};
    tbl[2]  = '{"rst2",     1, 1, 3, 0,  0, 0, 0, 0,       0};
    tbl[3]  = '{"str_c0",   0, 1, 4, 1,  1, 0, 0, 0,       0};
    tbl[4]  = '{"str_c1",   0, 1, 5, 1,  1, 0, 0, 0,       0};
    tbl[5]  = '{"str_c2",   0, 0, 0, 1,  1, 1, 1, 0,       1};
    tbl[6]  = '{"str_c3",   0, 0, 0, 1,  1, 1, 2, 0,       1};
    tbl[7]  = '{"str_c4",   0, 0, 0, 1,  1, 1, 3, 0,       1};
    tbl[8]  = '{"str_c5",   0, 0, 0, 1,  0, 1, 4, LAST_ON, 1};
    tbl[9]  = '{"str_c6",   0, 0, 0, 1,  0, 1, 5, 0,       1};
    tbl[10] = '{"str_c7",   0, 0, 0, 1,  0, 0, 0, 0,       0};
    tbl[11] = '{"empty0",   0, 0, 0, 1,  0, 0, 0, 0,       0};
    tbl[12] = '{"empty1",   0, 0, 0, 1,  0, 0, 0, 0,       0};
    tbl[13] = '{"one_rd",   0, 1, 7, 1,  1, 0, 0, 0,       0};
    tbl[14] = '{"one_wait", 0, 0, 0, 1,  0, 0, 0, 0,       0};
    tbl[15] = '{"one_vld",  0, 0, 0, 1,  0, 1, 7, 0,       1};
    tbl[16] = '{"one_done", 0, 0, 0, 1,  0, 0, 0, 0,       0};
    tbl[17] = '{"mid_a",    0, 1, 3, 0,  1, 0, 0, 0,       0};
    tbl[18] = '{"mid_b",    0, 0, 0, 0,  0, 0, 0, 0,       0};
    tbl[19] = '{"mid_c",    0, 1, 4, 0,  1, 1, 3, 0,       1};
    tbl[20] = '{"mid_rst",  1, 0, 0, 0,  0, 0, 0, 0,       0};
    tbl[21] = '{"mid_post", 0, 0, 0, 1,  0, 0, 0, 0,       0};
    tbl[22] = '{"mid_rd5",  0, 1, 5, 1,  1, 0, 0, 0,       0};
    tbl[23] = '{"mid_w5",   0, 0, 0, 1,  0, 0, 0, 0,       0};
    tbl[24] = '{"mid_v5",   0, 0, 0, 1,  0, 1, 5, 0,       1};
    tbl[25] = '{"mid_end",  0, 0, 0, 1,  0, 0, 0, 0,       0};

    rst = 1'b1;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      m_ready = tbl[i].rdy;
      if (tbl[i].push) push(tbl[i].pval);
      #1;
      chk(tbl[i].name, tbl[i].e_frd, tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_last, tbl[i].e_occ);
    end

    // Backpressure: six words queued, sink stalled for 10 cycles, then released.
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b0;
        if (c == 0) for (int k = 1; k <= 6; k++) push(3'(k));
        #1;
        if (f_rd) pulses++;
        if (c >= 2) chk("bp_hold", 1'b0, 1'b1, 3'd1, 1'b0, (c == 2) ? 2'd1 : 2'd2);
      end
      chk_int("bp_rd_pulses", pulses, 2);
      for (int r = 0; r < 7; r++) begin
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("bp_release", r <= 3, r <= 5, (r <= 5) ? 3'(r + 1) : 3'd0,
            LAST_ON && (r == 2), (r == 0) ? 2'd2 : ((r <= 5) ? 2'd1 : 2'd0));
      end
    end

    // Framing: counter cleared by reset, then 8 words streamed back-to-back.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("frm_rst", 1'b0, 1'b0, 3'd0, 1'b0, 2'd0);
    for (int c = 0; c < 11; c++) begin
      int w;
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      if (c == 0) for (int k = 1; k <= 8; k++) push(3'(k));
      #1;
      w = c - 1;
      chk("frm", c < 8, (c >= 2) && (c <= 9), 3'(w), LAST_ON && (w == 4 || w == 8),
          ((c >= 2) && (c <= 9)) ? 2'd1 : 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
